// File: rtl/iter_div_unit_pkg.sv
// Shared types and constants for the iterative radix-2 restoring divider.
// State encoding, widths and the absolute-value helper used at operand capture.
package iter_div_unit_pkg;

  localparam int DATA_W = 32;
  localparam int CNT_W  = $clog2(DATA_W);

  typedef enum logic [1:0] {
    DIV_IDLE = 2'd0,
    DIV_CALC = 2'd1,
    DIV_DONE = 2'd2
  } div_state_e;

  function automatic logic [DATA_W-1:0] abs_val(input logic [DATA_W-1:0] v);
    return v[DATA_W-1] ? (~v + 1'b1) : v;
  endfunction

endpackage

// File: rtl/iter_div_unit_if.sv
// E-stage divide request/response bundle between the pipeline and the divider.
// div is a level request; it launches only in IDLE, with flush low and no completion in the
// previous cycle. div_complete is a one-cycle response and cannot be back-pressured.
interface iter_div_unit_if;
  import iter_div_unit_pkg::*;

  logic              div;
  logic              div_signed;
  logic [DATA_W-1:0] dividend;
  logic [DATA_W-1:0] divisor;
  logic              flush;
  logic              div_complete;
  logic              busy;
  logic [DATA_W-1:0] quotient;
  logic [DATA_W-1:0] remainder;
  div_state_e        dbg_state;

  modport master (
    output div, div_signed, dividend, divisor, flush,
    input  div_complete, busy, quotient, remainder, dbg_state
  );

  modport slave (
    input  div, div_signed, dividend, divisor, flush,
    output div_complete, busy, quotient, remainder, dbg_state
  );

endinterface

// File: rtl/iter_div_unit_step.sv
// One restoring-division iteration: shift {rem,quo} left, subtract divisor if it fits.
// Purely combinational; the top reuses it every CALC cycle.
module iter_div_unit_step
  import iter_div_unit_pkg::*;
(
  input  logic [DATA_W-1:0] rem_i,
  input  logic [DATA_W-1:0] quo_i,
  input  logic [DATA_W-1:0] dvs_i,
  output logic [DATA_W-1:0] rem_o,
  output logic [DATA_W-1:0] quo_o
);

  logic [DATA_W:0]   part;
  logic [DATA_W-1:0] diff;
  logic              take;

  assign part = {rem_i, quo_i[DATA_W-1]};
  // A carry out of the shift always fits; the low bits of the modular difference are exact then.
  assign take = part[DATA_W] | (part[DATA_W-1:0] >= dvs_i);
  assign diff = part[DATA_W-1:0] - dvs_i;

  assign rem_o = take ? diff : part[DATA_W-1:0];
  assign quo_o = {quo_i[DATA_W-2:0], take};

endmodule

// File: rtl/iter_div_unit.sv
// DIV/DIVU unit: FSM, iteration counter, sign handling and LO/HI result registers.
// One quotient bit per clock; completion pulse DATA_W+1 cycles after the launch cycle.
module iter_div_unit
  import iter_div_unit_pkg::*;
(
  input  logic           clk,
  input  logic           reset,
  iter_div_unit_if.slave div_if
);

  div_state_e        state_q, state_d;
  logic [CNT_W-1:0]  cnt_q, cnt_d;
  logic [DATA_W-1:0] rem_q, rem_d, quo_q, quo_d, dvs_q, dvs_d;
  logic [DATA_W-1:0] quotient_q, quotient_d, remainder_q, remainder_d;
  logic              qneg_q, qneg_d, rneg_q, rneg_d, done_q;
  logic [DATA_W-1:0] step_rem, step_quo;
  logic              start, complete, busy, by_zero, apply_sign;

  assign by_zero    = (div_if.divisor == '0);
  assign apply_sign = div_if.div_signed & ~by_zero;
  // done_q blocks the same still-asserted request from relaunching right after completion.
  assign start      = (state_q == DIV_IDLE) & div_if.div & ~div_if.flush & ~done_q;

  iter_div_unit_step u_step (
    .rem_i (rem_q),
    .quo_i (quo_q),
    .dvs_i (dvs_q),
    .rem_o (step_rem),
    .quo_o (step_quo)
  );

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) state_q <= DIV_IDLE;
    else        state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      DIV_IDLE: if (start) state_d = DIV_CALC;
      DIV_CALC: begin
        if (div_if.flush)                        state_d = DIV_IDLE;
        else if (cnt_q == CNT_W'(DATA_W - 1))    state_d = DIV_DONE;
      end
      DIV_DONE: state_d = DIV_IDLE;
      default:  state_d = DIV_IDLE;
    endcase
  end

  always_comb begin
    complete = (state_q == DIV_DONE) & ~div_if.flush;
    busy     = (state_q != DIV_IDLE);
  end

  always_comb begin
    cnt_d       = cnt_q;
    rem_d       = rem_q;
    quo_d       = quo_q;
    dvs_d       = dvs_q;
    qneg_d      = qneg_q;
    rneg_d      = rneg_q;
    quotient_d  = quotient_q;
    remainder_d = remainder_q;
    if (start) begin
      // Divide-by-zero keeps the raw dividend so the remainder comes out unmodified.
      rem_d  = '0;
      quo_d  = apply_sign ? abs_val(div_if.dividend) : div_if.dividend;
      dvs_d  = div_if.div_signed ? abs_val(div_if.divisor) : div_if.divisor;
      cnt_d  = '0;
      qneg_d = apply_sign & (div_if.dividend[DATA_W-1] ^ div_if.divisor[DATA_W-1]);
      rneg_d = apply_sign & div_if.dividend[DATA_W-1];
    end else if (state_q == DIV_CALC && !div_if.flush) begin
      rem_d = step_rem;
      quo_d = step_quo;
      cnt_d = cnt_q + 1'b1;
    end
    if (complete) begin
      quotient_d  = qneg_q ? (~quo_q + 1'b1) : quo_q;
      remainder_d = rneg_q ? (~rem_q + 1'b1) : rem_q;
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      cnt_q       <= '0;
      rem_q       <= '0;
      quo_q       <= '0;
      dvs_q       <= '0;
      qneg_q      <= 1'b0;
      rneg_q      <= 1'b0;
      done_q      <= 1'b0;
      quotient_q  <= '0;
      remainder_q <= '0;
    end else begin
      cnt_q       <= cnt_d;
      rem_q       <= rem_d;
      quo_q       <= quo_d;
      dvs_q       <= dvs_d;
      qneg_q      <= qneg_d;
      rneg_q      <= rneg_d;
      done_q      <= complete;
      quotient_q  <= quotient_d;
      remainder_q <= remainder_d;
    end
  end

  assign div_if.div_complete = complete;
  assign div_if.busy         = busy;
  assign div_if.quotient     = quotient_q;
  assign div_if.remainder    = remainder_q;
  assign div_if.dbg_state    = state_q;

endmodule

// File: tb/tb_iter_div_unit.sv
// Bench for iter_div_unit: directed corner cases plus random DIV/DIVU traffic,
// with expected results queued at issue time and checked by an independent monitor.
module tb_iter_div_unit;
  import iter_div_unit_pkg::*;

  logic        clk;
  logic        reset;
  int          cyc = 0;
  int          total = 0;
  int          bad = 0;
  int          ready_cyc = 0;
  int          n_issued = 0;
  int          n_pulses = 0;
  logic [63:0] exp_q[$];
  int          start_q[$];
  logic [63:0] last_res = '0;

  iter_div_unit_if bus ();

  iter_div_unit dut (
    .clk    (clk),
    .reset  (reset),
    .div_if (bus)
  );

  // clock / cycle count
  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  always @(posedge clk) cyc <= cyc + 1;

  initial begin
    #400000;
    $display("FAIL watchdog: simulation time limit reached at cycle %0d", cyc);
    $fatal(1, "watchdog");
  end

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at cycle %0d", name, act, exp, cyc);
    end
  endtask

  // reference model: {remainder, quotient} from plain integer arithmetic
  function automatic logic [63:0] ref_div(input logic [31:0] a, input logic [31:0] b, input logic s);
    longint     sa, sb;
    logic [31:0] q, r;
    if (b == 32'd0) begin
      q = 32'hFFFF_FFFF;
      r = a;
    end else if (s) begin
      sa = longint'(signed'(a));
      sb = longint'(signed'(b));
      q  = 32'(sa / sb);
      r  = 32'(sa % sb);
    end else begin
      q = a / b;
      r = a % b;
    end
    return {r, q};
  endfunction

  // driver tasks
  task automatic issue(input logic [31:0] a, input logic [31:0] b, input logic s);
    while (cyc < ready_cyc) @(negedge clk);
    bus.div_signed = s;
    bus.dividend   = a;
    bus.divisor    = b;
    bus.div        = 1'b1;
    last_res       = ref_div(a, b, s);
    exp_q.push_back(last_res);
    start_q.push_back(cyc);
    n_issued++;
  endtask

  task automatic finish_div(input int hold);
    int n;
    @(negedge clk);
    bus.dividend   = $urandom;
    bus.divisor    = $urandom;
    bus.div_signed = 1'($urandom_range(0, 1));
    n = 1;
    while (bus.div_complete !== 1'b1 && n < 40) begin
      @(negedge clk);
      n++;
    end
    if (bus.div_complete !== 1'b1) begin
      chk("pulse_timeout", 64'(bus.div_complete), 64'd1);
      exp_q.delete();
      start_q.delete();
    end
    ready_cyc = cyc + 2;
    repeat (hold) @(negedge clk);
    bus.div = 1'b0;
  endtask

  task automatic flush_div(input logic [31:0] a, input logic [31:0] b, input logic s, input int iter);
    while (cyc < ready_cyc) @(negedge clk);
    bus.div_signed = s;
    bus.dividend   = a;
    bus.divisor    = b;
    bus.div        = 1'b1;
    repeat (iter + 1) @(negedge clk);
    bus.flush = 1'b1;
    #1;
    chk("flush_no_pulse", 64'(bus.div_complete), 64'd0);
    chk("flush_busy_before", 64'(bus.busy), 64'd1);
    @(negedge clk);
    bus.flush = 1'b0;
    bus.div   = 1'b0;
    #1;
    chk("flush_busy_after", 64'(bus.busy), 64'd0);
    chk("flush_keep_q", 64'(bus.quotient), 64'(last_res[31:0]));
    chk("flush_keep_r", 64'(bus.remainder), 64'(last_res[63:32]));
  endtask

  task automatic reset_run(input logic [31:0] a, input logic [31:0] b, input logic s,
                           input logic [31:0] a2, input logic [31:0] b2, input logic s2);
    while (cyc < ready_cyc) @(negedge clk);
    bus.div_signed = s;
    bus.dividend   = a;
    bus.divisor    = b;
    bus.div        = 1'b1;
    repeat (21) @(negedge clk);
    #2 reset = 1'b0;
    #1;
    chk("rst_quotient", 64'(bus.quotient), 64'd0);
    chk("rst_remainder", 64'(bus.remainder), 64'd0);
    chk("rst_busy", 64'(bus.busy), 64'd0);
    chk("rst_complete", 64'(bus.div_complete), 64'd0);
    chk("rst_state", 64'(bus.dbg_state), 64'(DIV_IDLE));
    last_res = '0;
    @(negedge clk);
    @(negedge clk);
    chk("rst_hold_busy", 64'(bus.busy), 64'd0);
    bus.div_signed = s2;
    bus.dividend   = a2;
    bus.divisor    = b2;
    reset          = 1'b1;
    last_res       = ref_div(a2, b2, s2);
    exp_q.push_back(last_res);
    start_q.push_back(cyc);
    n_issued++;
  endtask

  // scoreboard monitor: pops on every completion pulse, checks results one cycle later
  initial begin
    logic [63:0] e;
    int          s;
    logic        pend;
    pend = 1'b0;
    e    = '0;
    forever begin
      @(negedge clk);
      #1;
      if (pend) begin
        chk("quotient", 64'(bus.quotient), 64'(e[31:0]));
        chk("remainder", 64'(bus.remainder), 64'(e[63:32]));
        chk("busy_after_done", 64'(bus.busy), 64'd0);
        pend = 1'b0;
      end
      if (reset === 1'b1 && bus.div_complete === 1'b1) begin
        n_pulses++;
        if (start_q.size() == 0) begin
          chk("unexpected_pulse", 64'(bus.div_complete), 64'd0);
        end else begin
          s = start_q.pop_front();
          e = exp_q.pop_front();
          chk("latency", 64'(cyc - s), 64'd33);
          chk("busy_in_done", 64'(bus.busy), 64'd1);
          pend = 1'b1;
        end
      end
    end
  end

  // stimulus
  initial begin
    reset          = 1'b0;
    bus.div        = 1'b0;
    bus.div_signed = 1'b0;
    bus.dividend   = '0;
    bus.divisor    = '0;
    bus.flush      = 1'b0;
    repeat (3) @(negedge clk);
    #1;
    chk("init_quotient", 64'(bus.quotient), 64'd0);
    chk("init_remainder", 64'(bus.remainder), 64'd0);
    chk("init_busy", 64'(bus.busy), 64'd0);
    chk("init_complete", 64'(bus.div_complete), 64'd0);
    chk("init_state", 64'(bus.dbg_state), 64'(DIV_IDLE));
    @(negedge clk);
    reset = 1'b1;
    @(negedge clk);

    issue(32'd100, 32'd7, 1'b0);               finish_div(1);
    issue(32'hFFFF_FFF9, 32'd2, 1'b1);         finish_div(1);
    issue(32'd7, 32'hFFFF_FFFE, 1'b1);         finish_div(1);
    issue(32'h8000_0000, 32'hFFFF_FFFF, 1'b1); finish_div(1);
    issue(32'h1234_5678, 32'd0, 1'b0);         finish_div(1);
    issue(32'hFFFF_FFF9, 32'd0, 1'b1);         finish_div(1);
    issue(32'hFFFF_FFFF, 32'hFFFF_FFFF, 1'b0); finish_div(0);

    flush_div(32'd5000, 32'd3, 1'b0, 10);
    issue(32'd5000, 32'd3, 1'b0);              finish_div(1);
    flush_div(32'hDEAD_BEEF, 32'd17, 1'b1, 32);
    issue(32'hCAFE_0001, 32'd9, 1'b1);         finish_div(1);

    // stalled instruction keeps div high past completion, then goes away
    issue(32'd1_000_000, 32'd999, 1'b0);       finish_div(2);
    repeat (40) @(negedge clk);
    #1;
    chk("no_relaunch_busy", 64'(bus.busy), 64'd0);
    chk("no_relaunch_count", 64'(n_pulses), 64'(n_issued));

    issue(32'hFFFF_0000, 32'd255, 1'b1);       finish_div(2);
    issue(32'd77, 32'd5, 1'b0);                finish_div(1);

    reset_run(32'd900, 32'd7, 1'b0, 32'hFFFF_FF00, 32'd13, 1'b1);
    finish_div(1);

    for (int i = 0; i < 24; i++) begin
      logic [31:0] a, b;
      logic        s;
      a = $urandom;
      s = 1'($urandom_range(0, 1));
      case ($urandom_range(0, 5))
        0:       b = 32'd0;
        1:       b = $urandom_range(1, 15);
        2:       b = 32'hFFFF_FFFF;
        3:       b = $urandom;
        4:       b = -$urandom_range(1, 100);
        default: b = $urandom >> $urandom_range(1, 31);
      endcase
      if ($urandom_range(0, 7) == 0) a = 32'h8000_0000;
      issue(a, b, s);
      finish_div($urandom_range(0, 2));
    end

    repeat (40) @(negedge clk);
    #1;
    chk("sb_empty", 64'(exp_q.size()), 64'd0);
    chk("pulse_count", 64'(n_pulses), 64'(n_issued));
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
